uart_modem_ctrl: RTL and testbench
==================================

// Module: uart_modem_ctrl
// PURPOSE
//  UART-side modem control/status logic: the far end of the modem pads the modem agent drives.
//  Synchronises active-low pads cts/dsr/ri/dcd, keeps the 16550-style MSR (status + delta bits,
//  clear-on-read) and MCR, drives rts/dtr, supports loopback, raises the modem-status interrupt.
//  Sits beside the UART APB register file; the register file decodes addresses and strobes.
// PARAMETERS
//  SYNC_STAGES  2  flops per pad synchroniser (>=2)
// PORTS
//  PCLK       in   1  sole clock, rising edge
//  PRESETn    in   1  asynchronous active-low reset
//  mcr_wr     in   1  1-cycle strobe: load mcr_wdata into MCR
//  mcr_wdata  in   5  [0]DTR [1]RTS [2]OUT1 [3]OUT2 [4]LOOP
//  msr_rd     in   1  1-cycle strobe: MSR read this cycle, clear deltas
//  ier_ms     in   1  modem-status interrupt enable (IER[3])
//  cts_pad_i  in   1  clear-to-send, active-low pad
//  dsr_pad_i  in   1  data-set-ready, active-low pad
//  ri_pad_i   in   1  ring indicator, active-low pad
//  dcd_pad_i  in   1  carrier detect, active-low pad
//  rts_pad_o  out  1  = MCR.RTS, forced 0 in loopback
//  dtr_pad_o  out  1  = MCR.DTR, forced 0 in loopback
//  mcr        out  5  MCR register contents
//  msr        out  8  [0]DCTS [1]DDSR [2]TERI [3]DDCD [4]CTS [5]DSR [6]RI [7]DCD
//  modem_int  out  1  ier_ms & |msr[3:0]
// BEHAVIOUR
//  Reset: sync flops 1 (pads idle high); msr 8'h00; mcr 5'h00; rts/dtr 0; modem_int 0.
//  Sync: each pad -> SYNC_STAGES-flop chain; sync value s_x. Inverted: mi_x = ~s_x (1 = asserted).
//  Loopback (mcr[4]=1): mi_cts=RTS, mi_dsr=DTR, mi_ri=OUT1, mi_dcd=OUT2 (MCR bits); pads ignored
//   (chains keep sampling); rts_pad_o/dtr_pad_o = 0.
//  Status: msr[7:4] <= {mi_dcd,mi_ri,mi_dsr,mi_cts} every cycle. Pad edge at cycle N visible
//   in msr at edge N+SYNC_STAGES+1 (3 edges default). Loopback path: 1 edge after MCR change.
//  Deltas, set same edge as status update, comparing new mi_x vs current msr[7:4]:
//   DCTS/DDSR/DDCD on any change; TERI only on RI 1->0 (trailing edge of ring).
//  Deltas are sticky; cleared on edge after msr_rd=1. Set and clear same cycle: set wins.
//  msr output is the register (value read = pre-clear contents).
//  Entering/leaving loopback may change mi_x -> deltas set normally (16550 behaviour).
//  MCR: mcr <= mcr_wdata on mcr_wr; pad outputs follow next edge (registered path, no glitch).
//  modem_int: combinational from registered deltas and ier_ms; drops edge after clearing read.
//  PRESETn assertion mid-operation: all state to reset values immediately, pending deltas lost.
// STRUCTURE
//  uart_modem_pkg: MCR/MSR bit index localparams (MCR_DTR.., MSR_DCTS..), mcr_t/msr_t packed typedefs.
//  Sub-module uart_sync_bit #(STAGES, RST_VAL): single-bit synchroniser, instanced x4.
//  Top: MCR reg, loopback mux, MSR status+delta regs, interrupt gate.
// TESTING
//  1 Reset: PRESETn low mid-traffic -> msr=00, mcr=00, rts/dtr=0, modem_int=0 asynchronously.
//  2 cts_pad_i 1->0, ier_ms=1 -> 3 edges later msr=8'h11, modem_int=1; msr_rd -> msr=8'h10, int 0.
//  3 ri_pad_i 1->0 -> msr=8'h40 (no TERI); ri_pad_i 0->1 -> msr=8'h04 (TERI); read -> 8'h00.
//  4 dsr change coinciding with msr_rd of earlier DDCD -> DDCD cleared, DDSR retained.
//  5 mcr write 5'h1F -> rts/dtr=0, msr[7:4]=F, deltas DCTS/DDSR/DDCD set; write 5'h03 no loop
//    -> rts=1, dtr=1, msr[7:4] from pads.
//  6 Glitch: 1-cycle pad pulse shorter than sync -> status follows sampled value; delta pair checked.

Source files
------------

// File: rtl/uart_modem_pkg.sv
// Shared bit positions and packed register layouts for the UART modem control/status block.
package uart_modem_pkg;

  localparam int unsigned MCR_W = 5;
  localparam int unsigned MSR_W = 8;

  localparam int unsigned MCR_DTR  = 0;
  localparam int unsigned MCR_RTS  = 1;
  localparam int unsigned MCR_OUT1 = 2;
  localparam int unsigned MCR_OUT2 = 3;
  localparam int unsigned MCR_LOOP = 4;

  localparam int unsigned MSR_DCTS = 0;
  localparam int unsigned MSR_DDSR = 1;
  localparam int unsigned MSR_TERI = 2;
  localparam int unsigned MSR_DDCD = 3;
  localparam int unsigned MSR_CTS  = 4;
  localparam int unsigned MSR_DSR  = 5;
  localparam int unsigned MSR_RI   = 6;
  localparam int unsigned MSR_DCD  = 7;

  typedef struct packed {
    logic loop;
    logic out2;
    logic out1;
    logic rts;
    logic dtr;
  } mcr_t;

  typedef struct packed {
    logic dcd;
    logic ri;
    logic dsr;
    logic cts;
    logic ddcd;
    logic teri;
    logic ddsr;
    logic dcts;
  } msr_t;

endpackage

// File: rtl/uart_sync_bit.sv
// Single-bit multi-flop synchroniser with a configurable reset value.
module uart_sync_bit #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input into the bottom of the chain.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  // Chain register; resets to the pad idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {STAGES{RST_VAL}};
    else        sync_q <= sync_d;
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_modem_ctrl.sv
// UART modem control/status: pad synchronisers, MCR, loopback mux, 16550-style MSR and interrupt.
module uart_modem_ctrl
  import uart_modem_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             mcr_wr,
  input  logic [MCR_W-1:0] mcr_wdata,
  input  logic             msr_rd,
  input  logic             ier_ms,
  input  logic             cts_pad_i,
  input  logic             dsr_pad_i,
  input  logic             ri_pad_i,
  input  logic             dcd_pad_i,
  output logic             rts_pad_o,
  output logic             dtr_pad_o,
  output logic [MCR_W-1:0] mcr,
  output logic [MSR_W-1:0] msr,
  output logic             modem_int
);

  logic s_cts, s_dsr, s_ri, s_dcd;
  logic mi_cts, mi_dsr, mi_ri, mi_dcd;

  mcr_t mcr_q, mcr_d;
  msr_t msr_q, msr_d;
  logic rts_q, rts_d;
  logic dtr_q, dtr_d;

  uart_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cts (
    .clk(PCLK), .rst_n(PRESETn), .d_i(cts_pad_i), .q_o(s_cts)
  );
  uart_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_dsr (
    .clk(PCLK), .rst_n(PRESETn), .d_i(dsr_pad_i), .q_o(s_dsr)
  );
  uart_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ri (
    .clk(PCLK), .rst_n(PRESETn), .d_i(ri_pad_i), .q_o(s_ri)
  );
  uart_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_dcd (
    .clk(PCLK), .rst_n(PRESETn), .d_i(dcd_pad_i), .q_o(s_dcd)
  );

  // MCR load and pad-output next values; pad outputs are derived from the next MCR
  // so they leave their own flops in step with mcr and cannot glitch.
  always_comb begin
    mcr_d = mcr_q;
    if (mcr_wr) mcr_d = mcr_t'(mcr_wdata);
    rts_d = mcr_d.rts & ~mcr_d.loop;
    dtr_d = mcr_d.dtr & ~mcr_d.loop;
  end

  // Modem inputs (1 = asserted): MCR bits in loopback, inverted synchronised pads otherwise.
  always_comb begin
    if (mcr_q.loop) begin
      mi_cts = mcr_q.rts;
      mi_dsr = mcr_q.dtr;
      mi_ri  = mcr_q.out1;
      mi_dcd = mcr_q.out2;
    end else begin
      mi_cts = ~s_cts;
      mi_dsr = ~s_dsr;
      mi_ri  = ~s_ri;
      mi_dcd = ~s_dcd;
    end
  end

  // MSR status tracks mi_x every cycle; deltas are sticky, cleared by a read, and a new
  // change in the same cycle as the read wins over the clear.
  always_comb begin
    msr_d = msr_q;
    if (msr_rd) begin
      msr_d.dcts = 1'b0;
      msr_d.ddsr = 1'b0;
      msr_d.teri = 1'b0;
      msr_d.ddcd = 1'b0;
    end
    if (mi_cts != msr_q.cts)     msr_d.dcts = 1'b1;
    if (mi_dsr != msr_q.dsr)     msr_d.ddsr = 1'b1;
    if (msr_q.ri && !mi_ri)      msr_d.teri = 1'b1;
    if (mi_dcd != msr_q.dcd)     msr_d.ddcd = 1'b1;
    msr_d.cts = mi_cts;
    msr_d.dsr = mi_dsr;
    msr_d.ri  = mi_ri;
    msr_d.dcd = mi_dcd;
  end

  // Register bank.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      mcr_q <= '0;
      msr_q <= '0;
      rts_q <= 1'b0;
      dtr_q <= 1'b0;
    end else begin
      mcr_q <= mcr_d;
      msr_q <= msr_d;
      rts_q <= rts_d;
      dtr_q <= dtr_d;
    end
  end

  assign mcr       = mcr_q;
  assign msr       = msr_q;
  assign rts_pad_o = rts_q;
  assign dtr_pad_o = dtr_q;
  assign modem_int = ier_ms & (msr_q.dcts | msr_q.ddsr | msr_q.teri | msr_q.ddcd);

endmodule

// File: tb/tb_uart_modem_ctrl.sv
module tb_uart_modem_ctrl;

  logic       PCLK;
  logic       PRESETn;
  logic       mcr_wr;
  logic [4:0] mcr_wdata;
  logic       msr_rd;
  logic       ier_ms;
  logic       cts_pad_i, dsr_pad_i, ri_pad_i, dcd_pad_i;
  logic       rts_pad_o, dtr_pad_o;
  logic [4:0] mcr;
  logic [7:0] msr;
  logic       modem_int;

  int n_checks;
  int n_errors;

  uart_modem_ctrl #(.SYNC_STAGES(2)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .mcr_wr(mcr_wr), .mcr_wdata(mcr_wdata),
    .msr_rd(msr_rd), .ier_ms(ier_ms),
    .cts_pad_i(cts_pad_i), .dsr_pad_i(dsr_pad_i),
    .ri_pad_i(ri_pad_i), .dcd_pad_i(dcd_pad_i),
    .rts_pad_o(rts_pad_o), .dtr_pad_o(dtr_pad_o),
    .mcr(mcr), .msr(msr), .modem_int(modem_int)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic read_msr();
    msr_rd = 1'b1;
    step(1);
    msr_rd = 1'b0;
  endtask

  task automatic write_mcr(input logic [4:0] v);
    mcr_wr    = 1'b1;
    mcr_wdata = v;
    step(1);
    mcr_wr    = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    PRESETn   = 1'b0;
    mcr_wr    = 1'b0;
    mcr_wdata = '0;
    msr_rd    = 1'b0;
    ier_ms    = 1'b1;
    cts_pad_i = 1'b1;
    dsr_pad_i = 1'b1;
    ri_pad_i  = 1'b1;
    dcd_pad_i = 1'b1;
    step(2);
    check_eq("rst_msr", msr, 8'h00);
    check_eq("rst_mcr", {3'b0, mcr}, 8'h00);
    check_eq("rst_int", {7'b0, modem_int}, 8'h00);
    PRESETn = 1'b1;
    step(4);
    check_eq("idle_msr", msr, 8'h00);

    // CTS assertion: three edges of latency, then read clears the delta.
    cts_pad_i = 1'b0;
    step(2);
    check_eq("cts_latency", msr, 8'h00);
    step(1);
    check_eq("cts_msr", msr, 8'h11);
    check_eq("cts_int", {7'b0, modem_int}, 8'h01);
    ier_ms = 1'b0;
    #1;
    check_eq("int_masked", {7'b0, modem_int}, 8'h00);
    ier_ms = 1'b1;
    read_msr();
    check_eq("cts_rd_msr", msr, 8'h10);
    check_eq("cts_rd_int", {7'b0, modem_int}, 8'h00);
    cts_pad_i = 1'b1;
    step(3);
    check_eq("cts_deassert", msr, 8'h01);
    read_msr();
    check_eq("cts_clr", msr, 8'h00);

    // Ring: leading edge sets no TERI, trailing edge does.
    ri_pad_i = 1'b0;
    step(3);
    check_eq("ri_lead", msr, 8'h40);
    ri_pad_i = 1'b1;
    step(3);
    check_eq("ri_trail", msr, 8'h04);
    read_msr();
    check_eq("ri_clr", msr, 8'h00);

    // DSR change landing on the same edge as the read that clears DDCD.
    dcd_pad_i = 1'b0;
    step(3);
    check_eq("dcd_set", msr, 8'h88);
    dsr_pad_i = 1'b0;
    step(2);
    msr_rd = 1'b1;
    step(1);
    msr_rd = 1'b0;
    check_eq("rd_vs_set", msr, 8'hA2);
    dcd_pad_i = 1'b1;
    dsr_pad_i = 1'b1;
    step(3);
    check_eq("dsr_dcd_off", msr, 8'h0A);
    read_msr();
    check_eq("dsr_dcd_clr", msr, 8'h00);

    // Loopback: pads ignored, pad outputs forced low.
    write_mcr(5'h1F);
    check_eq("lb_mcr", {3'b0, mcr}, 8'h1F);
    check_eq("lb_pads", {6'b0, rts_pad_o, dtr_pad_o}, 8'h00);
    check_eq("lb_msr_lat", msr, 8'h00);
    step(1);
    check_eq("lb_msr", msr, 8'hFB);
    cts_pad_i = 1'b0;
    step(3);
    check_eq("lb_pad_ignored", msr, 8'hFB);
    cts_pad_i = 1'b1;
    step(3);
    write_mcr(5'h03);
    check_eq("nolb_pads", {6'b0, rts_pad_o, dtr_pad_o}, 8'h03);
    step(1);
    check_eq("nolb_msr", msr, 8'h0F);
    read_msr();
    check_eq("nolb_clr", msr, 8'h00);

    // One-cycle CTS glitch caught by the first sync stage.
    cts_pad_i = 1'b0;
    step(1);
    cts_pad_i = 1'b1;
    step(2);
    check_eq("glitch_hi", msr, 8'h11);
    step(1);
    check_eq("glitch_lo", msr, 8'h01);
    read_msr();
    check_eq("glitch_clr", msr, 8'h00);

    // Asynchronous reset in the middle of activity.
    dcd_pad_i = 1'b0;
    step(3);
    check_eq("pre_rst_int", {7'b0, modem_int}, 8'h01);
    #3;
    PRESETn = 1'b0;
    #1;
    check_eq("arst_msr", msr, 8'h00);
    check_eq("arst_mcr", {3'b0, mcr}, 8'h00);
    check_eq("arst_pads", {6'b0, rts_pad_o, dtr_pad_o}, 8'h00);
    check_eq("arst_int", {7'b0, modem_int}, 8'h00);
    step(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
